estagio_operandos_ula: RTL
==========================

Name: estagio_operandos_ula

Overview:
Operand-fetch stage sitting directly upstream of the 8-bit ALU. It holds an 8-entry register bank. Each issued instruction reads two source registers, or one register plus an immediate. The operands and the ALU operation code go into an output register that drives the ALU inputs entrada1, entrada2 and sinal_ula. The ALU result comes back through the write port. A valid/stall handshake lets downstream logic freeze the stage.

Parameters:
LARGURA_DADO, 8, data width of registers, operands and immediate
NUM_REG, 8, number of registers; address width is clog2(NUM_REG) = 3

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous reset, active-low
emite  in  1  upstream issues an instruction this cycle
pronto  out  1  stage can accept an issue this cycle
end_leitura1  in  3  source register A address
end_leitura2  in  3  source register B address
usa_imediato  in  1  1 = entrada2 takes imediato instead of register B
imediato  in  8  immediate operand
sinal_ula_in  in  3  ALU operation code to forward
escreve  in  1  write-back enable
end_escrita  in  3  write-back register address
dado_escrita  in  8  write-back data (ALU result)
parada  in  1  downstream stall request
entrada1  out  8  ALU operand A (registered)
entrada2  out  8  ALU operand B (registered)
sinal_ula  out  3  ALU operation code (registered)
valido  out  1  entrada1/entrada2/sinal_ula hold a valid instruction

Behaviour:
- Reset: reset_n low clears immediately, independent of clock, all registers in the bank and entrada1, entrada2, sinal_ula, valido to 0. Reset mid-operation discards any held instruction.
- Register 0 always reads 0. Writes to address 0 are ignored.
- Write port: at posedge, if escreve and end_escrita != 0, bank[end_escrita] <= dado_escrita.
- Read port: combinational read of bank[end_leitura1] and bank[end_leitura2].
- pronto = !parada || !valido.
- Output register, at posedge:
  - if pronto: valido <= emite.
  - if pronto and emite: entrada1 <= bankA; entrada2 <= (usa_imediato ? imediato : bankB); sinal_ula <= sinal_ula_in.
  - if pronto and !emite: data outputs keep their previous values; only valido drops.
  - if !pronto: all outputs hold.
- emite while pronto=0 is an upstream protocol violation. The instruction is dropped and the bank is unaffected.
- Latency: 1 cycle from accepted issue to valido=1.
- Write and read to the same register in the same cycle: governed by the optional feature below.
- Simultaneous write and stall: the write always completes. A stall never blocks write-back.
- sinal_ula_in is passed through unchanged, including unused codes 101–111. The ALU resolves those codes to 0.

Optional Feature:
Macro BYPASS_ESCRITA_EN.
- Defined: if escreve=1, end_escrita != 0 and end_escrita equals a read address in the same cycle, that operand takes dado_escrita. Forwarding applies per port independently. Register B forwarding is irrelevant when usa_imediato=1.
- Undefined: a same-cycle read returns the pre-write bank value. The new value is visible from the next cycle onward.

Decomposition:
- Shared package pacote_processador:
  - constants LARGURA_DADO=8, NUM_REG=8, LARGURA_END=3
  - ALU operation codes ULA_AND=3'b000, ULA_OR=3'b001, ULA_ADD=3'b010, ULA_SUB=3'b011, ULA_SLT=3'b100
- One natural sub-module, banco_registradores: storage, zero register, two read ports, one write port and the bypass option.
- The top module adds the immediate mux, output register and handshake.

Test Plan:
- Reset: pulse reset_n low between edges -> all outputs 0 immediately, valido=0; reading any address afterwards yields 0.
- Write then read: write r3=0x5A, then issue end_leitura1=3, end_leitura2=0, sinal_ula_in=ULA_ADD -> next cycle entrada1=0x5A, entrada2=0x00, sinal_ula=010, valido=1.
- Zero register and immediate: write r0=0xFF; issue A=0, usa_imediato=1, imediato=0x7F -> entrada1=0x00, entrada2=0x7F.
- Stall: valido=1 with parada=1 for 3 cycles while emite toggles -> outputs frozen and pronto=0; parada=0 with emite=1 -> new instruction appears one cycle later.
- Same-cycle write/read: r2=0x10, then in one cycle write r2=0x22 and issue A=2 -> entrada1=0x22 with BYPASS_ESCRITA_EN, 0x10 without.
- Unused opcode: issue sinal_ula_in=3'b111 -> sinal_ula=111 forwarded unchanged.

Source files
------------

// File: rtl/estagio_operandos_ula_pkg.sv
// ---------------------------------------------------------------------------
// pacote_processador
// Shared constants and ALU operation codes for the processor datapath.
//   LARGURA_DADO : data width of registers, operands and immediates
//   NUM_REG      : number of architectural registers
//   LARGURA_END  : register address width
//   op_ula_t     : ALU operation codes. Codes 101..111 are unused; the
//                  operand stage forwards them untouched and the ALU
//                  resolves them to 0.
// ---------------------------------------------------------------------------
package pacote_processador;

    localparam int LARGURA_DADO = 8;
    localparam int NUM_REG      = 8;
    localparam int LARGURA_END  = 3;

    typedef enum logic [2:0] {
        ULA_AND = 3'b000,
        ULA_OR  = 3'b001,
        ULA_ADD = 3'b010,
        ULA_SUB = 3'b011,
        ULA_SLT = 3'b100
    } op_ula_t;

endpackage

// File: rtl/estagio_operandos_ula_if.sv
// ---------------------------------------------------------------------------
// estagio_operandos_ula_if
// Bus between the instruction issuer / write-back path (master) and the
// operand-fetch stage (slave).
//   issue      : emite, pronto, end_leitura1, end_leitura2, usa_imediato,
//                imediato, sinal_ula_in
//   write-back : escreve, end_escrita, dado_escrita
//   ALU side   : parada, entrada1, entrada2, sinal_ula, valido
// ---------------------------------------------------------------------------
interface estagio_operandos_ula_if #(
    parameter int LARGURA_DADO = pacote_processador::LARGURA_DADO,
    parameter int NUM_REG      = pacote_processador::NUM_REG
);

    localparam int LARGURA_END = $clog2(NUM_REG);

    logic                    emite;
    logic                    pronto;
    logic [LARGURA_END-1:0]  end_leitura1;
    logic [LARGURA_END-1:0]  end_leitura2;
    logic                    usa_imediato;
    logic [LARGURA_DADO-1:0] imediato;
    logic [2:0]              sinal_ula_in;
    logic                    escreve;
    logic [LARGURA_END-1:0]  end_escrita;
    logic [LARGURA_DADO-1:0] dado_escrita;
    logic                    parada;
    logic [LARGURA_DADO-1:0] entrada1;
    logic [LARGURA_DADO-1:0] entrada2;
    logic [2:0]              sinal_ula;
    logic                    valido;

    modport master (
        output emite, end_leitura1, end_leitura2, usa_imediato, imediato,
               sinal_ula_in, escreve, end_escrita, dado_escrita, parada,
        input  pronto, entrada1, entrada2, sinal_ula, valido
    );

    modport slave (
        input  emite, end_leitura1, end_leitura2, usa_imediato, imediato,
               sinal_ula_in, escreve, end_escrita, dado_escrita, parada,
        output pronto, entrada1, entrada2, sinal_ula, valido
    );

endinterface

// File: rtl/estagio_operandos_ula_banco.sv
// ---------------------------------------------------------------------------
// banco_registradores
// Register bank: NUM_REG x LARGURA_DADO, register 0 hardwired to zero,
// two combinational read ports, one synchronous write port.
//   clock, reset_n         : clock, asynchronous active-low clear
//   escreve/end_escrita/
//   dado_escrita           : write port (writes to address 0 are dropped)
//   end_leitura1/2         : read addresses
//   dado_leitura1/2        : read data
// Optional: BYPASS_ESCRITA_EN forwards same-cycle write data to a read
// port addressing the register being written; otherwise a same-cycle read
// returns the old contents.
// ---------------------------------------------------------------------------
module banco_registradores #(
    parameter int LARGURA_DADO = pacote_processador::LARGURA_DADO,
    parameter int NUM_REG      = pacote_processador::NUM_REG,
    localparam int LARGURA_END = $clog2(NUM_REG)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    escreve,
    input  logic [LARGURA_END-1:0]  end_escrita,
    input  logic [LARGURA_DADO-1:0] dado_escrita,
    input  logic [LARGURA_END-1:0]  end_leitura1,
    input  logic [LARGURA_END-1:0]  end_leitura2,
    output logic [LARGURA_DADO-1:0] dado_leitura1,
    output logic [LARGURA_DADO-1:0] dado_leitura2
);

    import pacote_processador::*;

    logic [LARGURA_DADO-1:0] regs [NUM_REG];
    logic                    escrita_valida;

    assign escrita_valida = escreve && (end_escrita != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (escrita_valida) begin
            regs[end_escrita] <= dado_escrita;
        end
    end

    // Address 0 is forced to zero on read, so regs[0] never matters.
    always_comb begin
        dado_leitura1 = (end_leitura1 == '0) ? '0 : regs[end_leitura1];
        dado_leitura2 = (end_leitura2 == '0) ? '0 : regs[end_leitura2];
`ifdef BYPASS_ESCRITA_EN
        if (escrita_valida && (end_escrita == end_leitura1)) begin
            dado_leitura1 = dado_escrita;
        end
        if (escrita_valida && (end_escrita == end_leitura2)) begin
            dado_leitura2 = dado_escrita;
        end
`endif
    end

endmodule

// File: rtl/estagio_operandos_ula.sv
// ---------------------------------------------------------------------------
// estagio_operandos_ula
// Operand-fetch stage in front of the 8-bit ALU. Reads two registers (or a
// register and an immediate) and registers them with the ALU opcode into
// entrada1/entrada2/sinal_ula, flagged by valido. Downstream may freeze the
// stage with parada; write-back is never blocked by a stall.
//   clock, reset_n : clock, asynchronous active-low clear
//   bus (slave)    : issue, write-back and ALU-side signals
// Optional: BYPASS_ESCRITA_EN (see banco_registradores).
// ---------------------------------------------------------------------------
module estagio_operandos_ula #(
    parameter int LARGURA_DADO = pacote_processador::LARGURA_DADO,
    parameter int NUM_REG      = pacote_processador::NUM_REG
) (
    input  logic                   clock,
    input  logic                   reset_n,
    estagio_operandos_ula_if.slave bus
);

    import pacote_processador::*;

    logic [LARGURA_DADO-1:0] leitura_a;
    logic [LARGURA_DADO-1:0] leitura_b;
    logic [LARGURA_DADO-1:0] operando_b;
    logic                    pronto;

    logic [LARGURA_DADO-1:0] entrada1_q;
    logic [LARGURA_DADO-1:0] entrada2_q;
    logic [2:0]              sinal_ula_q;
    logic                    valido_q;

    banco_registradores #(
        .LARGURA_DADO (LARGURA_DADO),
        .NUM_REG      (NUM_REG)
    ) u_banco (
        .clock         (clock),
        .reset_n       (reset_n),
        .escreve       (bus.escreve),
        .end_escrita   (bus.end_escrita),
        .dado_escrita  (bus.dado_escrita),
        .end_leitura1  (bus.end_leitura1),
        .end_leitura2  (bus.end_leitura2),
        .dado_leitura1 (leitura_a),
        .dado_leitura2 (leitura_b)
    );

    always_comb begin
        operando_b = bus.usa_imediato ? bus.imediato : leitura_b;
        // The held instruction can only be replaced once it is consumed or
        // when the register is empty.
        pronto     = !bus.parada || !valido_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entrada1_q  <= '0;
            entrada2_q  <= '0;
            sinal_ula_q <= '0;
            valido_q    <= 1'b0;
        end else if (pronto) begin
            valido_q <= bus.emite;
            if (bus.emite) begin
                entrada1_q  <= leitura_a;
                entrada2_q  <= operando_b;
                sinal_ula_q <= bus.sinal_ula_in;
            end
        end
    end

    assign bus.pronto    = pronto;
    assign bus.entrada1  = entrada1_q;
    assign bus.entrada2  = entrada2_q;
    assign bus.sinal_ula = sinal_ula_q;
    assign bus.valido    = valido_q;

endmodule
